decode_stage_pipe: RTL and testbench

- Registered, parametrised RV32I/Zicsr/Zifencei decode stage, placed between the fetch and execute stages.
- Decodes one 32-bit instruction into a control bundle plus a fully sign-extended XLEN immediate. Branch and jump offsets already include bit 0.
- Adds a valid/ready handshake, a 2-entry skid buffer, synchronous flush, illegal-instruction detection and a saturating illegal-instruction counter.

---
 rtl/decode_stage_pipe_if.sv | 35 +++
 rtl/decode_stage_pipe.sv | 225 ++++++++++++++++++++++
 tb/tb_decode_stage_pipe.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_pipe_if.sv
// Fetch-to-execute handshake bundle for the decode stage.
// The master side drives instructions and out_ready; the slave side is the decode stage.
interface decode_stage_pipe_if #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned PC_WIDTH = 32
) ();
    logic                in_valid;
    logic                in_ready;
    logic [31:0]         in_inst;
    logic [PC_WIDTH-1:0] in_pc;

    logic                out_valid;
    logic                out_ready;
    logic [PC_WIDTH-1:0] out_pc;
    logic [31:0]         out_inst;
    logic [4:0]          out_rd;
    logic [4:0]          out_rs1;
    logic [4:0]          out_rs2;
    logic [2:0]          out_func3;
    logic [6:0]          out_func7;
    logic [XLEN-1:0]     out_imm;
    logic [12:0]         out_ctrl;

    modport master (
        output in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_inst, out_rd, out_rs1, out_rs2,
               out_func3, out_func7, out_imm, out_ctrl
    );

    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_inst, out_rd, out_rs1, out_rs2,
               out_func3, out_func7, out_imm, out_ctrl
    );
endinterface

// File: rtl/decode_stage_pipe.sv
// RV32I/Zicsr/Zifencei decode stage: decodes on entry, stores decoded results in a
// 2-entry skid FIFO, and counts accepted illegal instructions (saturating).
module decode_stage_pipe #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned PC_WIDTH  = 32,
    parameter int unsigned CNT_WIDTH = 16,
    parameter bit          CSR_EN    = 1'b1,
    parameter bit          FENCE_EN  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    decode_stage_pipe_if.slave   bus,
    output logic [CNT_WIDTH-1:0] illegal_cnt
);
    localparam int unsigned CTRL_W = 13;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // ctrl bit positions
    localparam int unsigned C_ILLEGAL = 12;
    localparam int unsigned C_FENCE   = 11;
    localparam int unsigned C_CSR     = 10;
    localparam int unsigned C_LUI     = 9;
    localparam int unsigned C_AUIPC   = 8;
    localparam int unsigned C_JAL     = 7;
    localparam int unsigned C_JALR    = 6;
    localparam int unsigned C_BRANCH  = 5;
    localparam int unsigned C_WMEM    = 4;
    localparam int unsigned C_RMEM    = 3;
    localparam int unsigned C_MEM2REG = 2;
    localparam int unsigned C_ALUSRC  = 1;
    localparam int unsigned C_WREG    = 0;

    typedef struct packed {
        logic [PC_WIDTH-1:0] pc;
        logic [31:0]         inst;
        logic [XLEN-1:0]     imm;
        logic [CTRL_W-1:0]   ctrl;
    } entry_t;

    entry_t                 r_head;
    entry_t                 r_tail;
    logic [1:0]             r_count;
    logic                   r_out_valid;
    logic                   r_in_ready;
    logic [CNT_WIDTH-1:0]   r_illegal_cnt;

    logic [6:0]             w_op;
    logic [2:0]             w_f3;
    logic [6:0]             w_f7;
    logic [XLEN-1:0]        w_imm_i;
    logic [XLEN-1:0]        w_imm_s;
    logic [XLEN-1:0]        w_imm_b;
    logic [XLEN-1:0]        w_imm_u;
    logic [XLEN-1:0]        w_imm_j;
    logic [XLEN-1:0]        w_imm_csr;
    logic                   w_illegal;
    logic [CTRL_W-1:0]      w_ctrl;
    logic [XLEN-1:0]        w_imm;
    entry_t                 w_entry;
    logic                   w_acc;
    logic                   w_pop;
    logic [1:0]             w_count_nxt;

    assign w_op = bus.in_inst[6:0];
    assign w_f3 = bus.in_inst[14:12];
    assign w_f7 = bus.in_inst[31:25];

    assign w_imm_i   = XLEN'($signed(bus.in_inst[31:20]));
    assign w_imm_s   = XLEN'($signed({bus.in_inst[31:25], bus.in_inst[11:7]}));
    assign w_imm_b   = XLEN'($signed({bus.in_inst[31], bus.in_inst[7], bus.in_inst[30:25],
                                      bus.in_inst[11:8], 1'b0}));
    assign w_imm_u   = XLEN'($signed({bus.in_inst[31:12], 12'b0}));
    assign w_imm_j   = XLEN'($signed({bus.in_inst[31], bus.in_inst[19:12], bus.in_inst[20],
                                      bus.in_inst[30:21], 1'b0}));
    assign w_imm_csr = XLEN'(bus.in_inst[31:20]);

    // Opcode decode and illegal-encoding detection; illegal entries keep only ctrl[12]
    always_comb begin
        w_ctrl    = '0;
        w_imm     = '0;
        w_illegal = 1'b0;
        if (bus.in_inst[1:0] != 2'b11) begin
            w_illegal = 1'b1;
        end else begin
            unique case (w_op)
                OP_R: begin
                    w_ctrl[C_WREG] = 1'b1;
                    if (w_f7 != 7'b0000000 && w_f7 != 7'b0100000) w_illegal = 1'b1;
                    if (w_f7 == 7'b0100000 && w_f3 != 3'b000 && w_f3 != 3'b101) w_illegal = 1'b1;
                end
                OP_LOAD: begin
                    w_ctrl[C_WREG]    = 1'b1;
                    w_ctrl[C_ALUSRC]  = 1'b1;
                    w_ctrl[C_MEM2REG] = 1'b1;
                    w_ctrl[C_RMEM]    = 1'b1;
                    w_imm             = w_imm_i;
                    if (w_f3 == 3'b011 || w_f3 == 3'b110 || w_f3 == 3'b111) w_illegal = 1'b1;
                end
                OP_IMM: begin
                    w_ctrl[C_WREG]   = 1'b1;
                    w_ctrl[C_ALUSRC] = 1'b1;
                    w_imm            = w_imm_i;
                    if (w_f3 == 3'b001 && w_f7 != 7'b0000000) w_illegal = 1'b1;
                    if (w_f3 == 3'b101 && w_f7 != 7'b0000000 && w_f7 != 7'b0100000)
                        w_illegal = 1'b1;
                end
                OP_STORE: begin
                    w_ctrl[C_ALUSRC] = 1'b1;
                    w_ctrl[C_WMEM]   = 1'b1;
                    w_imm            = w_imm_s;
                    if (w_f3 > 3'b010) w_illegal = 1'b1;
                end
                OP_BRANCH: begin
                    w_ctrl[C_BRANCH] = 1'b1;
                    w_imm            = w_imm_b;
                    if (w_f3 == 3'b010 || w_f3 == 3'b011) w_illegal = 1'b1;
                end
                OP_JAL: begin
                    w_ctrl[C_WREG] = 1'b1;
                    w_ctrl[C_JAL]  = 1'b1;
                    w_imm          = w_imm_j;
                end
                OP_JALR: begin
                    w_ctrl[C_WREG]   = 1'b1;
                    w_ctrl[C_ALUSRC] = 1'b1;
                    w_ctrl[C_JALR]   = 1'b1;
                    w_imm            = w_imm_i;
                    if (w_f3 != 3'b000) w_illegal = 1'b1;
                end
                OP_LUI: begin
                    w_ctrl[C_WREG]   = 1'b1;
                    w_ctrl[C_ALUSRC] = 1'b1;
                    w_ctrl[C_LUI]    = 1'b1;
                    w_imm            = w_imm_u;
                end
                OP_AUIPC: begin
                    w_ctrl[C_WREG]   = 1'b1;
                    w_ctrl[C_ALUSRC] = 1'b1;
                    w_ctrl[C_AUIPC]  = 1'b1;
                    w_imm            = w_imm_u;
                end
                OP_SYSTEM: begin
                    w_ctrl[C_WREG] = 1'b1;
                    w_ctrl[C_CSR]  = 1'b1;
                    w_imm          = w_imm_csr;
                    if (!CSR_EN || w_f3 == 3'b100) w_illegal = 1'b1;
                end
                OP_FENCE: begin
                    w_ctrl[C_FENCE] = 1'b1;
                    if (!FENCE_EN || w_f3 > 3'b001) w_illegal = 1'b1;
                end
                default: w_illegal = 1'b1;
            endcase
        end
        if (w_illegal) begin
            w_ctrl            = '0;
            w_ctrl[C_ILLEGAL] = 1'b1;
            w_imm             = '0;
        end
    end

    assign w_entry = '{pc: bus.in_pc, inst: bus.in_inst, imm: w_imm, ctrl: w_ctrl};

    // Handshake and occupancy; flush blocks acceptance in its own cycle
    always_comb begin
        w_acc       = bus.in_valid & r_in_ready & ~flush;
        w_pop       = r_out_valid & bus.out_ready;
        w_count_nxt = r_count;
        if (flush)               w_count_nxt = 2'd0;
        else if (w_acc && !w_pop) w_count_nxt = r_count + 2'd1;
        else if (w_pop && !w_acc) w_count_nxt = r_count - 2'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= 2'd0;
            r_out_valid   <= 1'b0;
            r_in_ready    <= 1'b1;
            r_illegal_cnt <= '0;
        end else begin
            r_count     <= w_count_nxt;
            r_out_valid <= (w_count_nxt != 2'd0);
            r_in_ready  <= (w_count_nxt != 2'd2);
            // Head always holds the oldest entry so outputs come straight from a register
            unique case (r_count)
                2'd0: if (w_acc) r_head <= w_entry;
                2'd1: begin
                    if (w_acc && w_pop) r_head <= w_entry;
                    else if (w_acc)     r_tail <= w_entry;
                end
                default: if (w_pop) r_head <= r_tail;
            endcase
            if (w_acc && w_ctrl[C_ILLEGAL] && r_illegal_cnt != {CNT_WIDTH{1'b1}})
                r_illegal_cnt <= r_illegal_cnt + CNT_WIDTH'(1);
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_pc    = r_head.pc;
    assign bus.out_inst  = r_head.inst;
    assign bus.out_rd    = r_head.inst[11:7];
    assign bus.out_rs1   = r_head.inst[19:15];
    assign bus.out_rs2   = r_head.inst[24:20];
    assign bus.out_func3 = r_head.inst[14:12];
    assign bus.out_func7 = r_head.inst[31:25];
    assign bus.out_imm   = r_head.imm;
    assign bus.out_ctrl  = r_head.ctrl;
    assign illegal_cnt   = r_illegal_cnt;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed scoreboard bench for decode_stage_pipe: expected decode results are queued
// on acceptance and compared when the stage emits them.
module tb_decode_stage_pipe;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic [CW-1:0] illegal_cnt;

    decode_stage_pipe_if #(.XLEN(32), .PC_WIDTH(32)) bus ();

    decode_stage_pipe #(
        .XLEN(32), .PC_WIDTH(32), .CNT_WIDTH(CW), .CSR_EN(1'b1), .FENCE_EN(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus), .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] imm;
        logic [12:0] ctrl;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] pc_q  = 32'h0000_1000;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Scoreboard monitor: a pop happens at the next edge when out_valid & out_ready
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", 64'(bus.out_inst), 64'hDEAD);
            end else begin
                e = sb.pop_front();
                chk("out_pc",    64'(bus.out_pc),    64'(e.pc));
                chk("out_inst",  64'(bus.out_inst),  64'(e.inst));
                chk("out_imm",   64'(bus.out_imm),   64'(e.imm));
                chk("out_ctrl",  64'(bus.out_ctrl),  64'(e.ctrl));
                chk("out_rd",    64'(bus.out_rd),    64'(e.inst[11:7]));
                chk("out_rs1",   64'(bus.out_rs1),   64'(e.inst[19:15]));
                chk("out_rs2",   64'(bus.out_rs2),   64'(e.inst[24:20]));
                chk("out_func3", 64'(bus.out_func3), 64'(e.inst[14:12]));
                chk("out_func7", 64'(bus.out_func7), 64'(e.inst[31:25]));
            end
        end
    end

    // Offer one instruction until accepted (bounded); returns just after the accepting edge
    task automatic send(input logic [31:0] inst, input logic [31:0] imm, input logic [12:0] ctrl);
        int n   = 0;
        bit acc = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_inst  = inst;
        bus.in_pc    = pc_q;
        while (!acc && n < 20) begin
            @(negedge clk);
            acc = bus.in_ready;
            if (acc) sb.push_back('{pc: pc_q, inst: inst, imm: imm, ctrl: ctrl});
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) chk("accept_timeout", 64'd0, 64'd1);
        bus.in_valid = 1'b0;
        pc_q         = pc_q + 32'd4;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    logic [31:0] legal_inst [14] = '{
        32'h00500093, 32'hFE000CE3, 32'h001000EF, 32'h123452B7,
        32'hFE20AE23, 32'h00812183, 32'h80000217, 32'h300110F3,
        32'hC00020F3, 32'h0FF0000F, 32'hFFC100E7, 32'h002081B3,
        32'h402081B3, 32'h4030D093};
    logic [31:0] legal_imm [14] = '{
        32'h00000005, 32'hFFFFFFF8, 32'h00000800, 32'h12345000,
        32'hFFFFFFFC, 32'h00000008, 32'h80000000, 32'h00000300,
        32'h00000C00, 32'h00000000, 32'hFFFFFFFC, 32'h00000000,
        32'h00000000, 32'h00000403};
    logic [12:0] legal_ctrl [14] = '{
        13'h003, 13'h020, 13'h081, 13'h203,
        13'h012, 13'h00F, 13'h103, 13'h401,
        13'h401, 13'h800, 13'h043, 13'h001,
        13'h001, 13'h003};
    logic [31:0] illegal_inst [9] = '{
        32'h40309093, 32'h0000B183, 32'h00002063, 32'h000010E7,
        32'h00004073, 32'h0000200F, 32'h02000033, 32'h0000B023,
        32'h0000007F};

    initial begin
        rst           = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_inst   = 32'h0;
        bus.in_pc     = 32'h0;
        bus.out_ready = 1'b0;

        // Reset state
        #12;
        chk("rst_out_valid", 64'(bus.out_valid),  64'd0);
        chk("rst_in_ready",  64'(bus.in_ready),   64'd1);
        chk("rst_out_ctrl",  64'(bus.out_ctrl),   64'd0);
        chk("rst_out_imm",   64'(bus.out_imm),    64'd0);
        chk("rst_out_inst",  64'(bus.out_inst),   64'd0);
        chk("rst_ill_cnt",   64'(illegal_cnt),    64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // First-instruction latency: visible right after the accepting edge
        bus.out_ready = 1'b1;
        send(legal_inst[0], legal_imm[0], legal_ctrl[0]);
        chk("lat_out_valid", 64'(bus.out_valid), 64'd1);
        chk("lat_out_rd",    64'(bus.out_rd),    64'd1);
        chk("lat_out_imm",   64'(bus.out_imm),   64'h5);

        // Back-to-back legal decode patterns at full throughput
        for (int i = 1; i < 14; i++) send(legal_inst[i], legal_imm[i], legal_ctrl[i]);
        drain();

        // Stall: A,B fill the buffer, C is held while outputs stay on A
        bus.out_ready = 1'b0;
        send(32'h00500093, 32'h00000005, 13'h003);
        send(32'h123452B7, 32'h12345000, 13'h203);
        bus.in_valid = 1'b1;
        bus.in_inst  = 32'h001000EF;
        bus.in_pc    = pc_q;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_in_ready",  64'(bus.in_ready),  64'd0);
            chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
            chk("stall_out_inst",  64'(bus.out_inst),  64'h00500093);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        send(32'h001000EF, 32'h00000800, 13'h081);
        drain();

        // Flush with two entries buffered and in_valid high
        bus.out_ready = 1'b0;
        send(32'h00500093, 32'h00000005, 13'h003);
        send(32'h002081B3, 32'h00000000, 13'h001);
        bus.in_valid = 1'b1;
        bus.in_inst  = 32'h00000000;
        flush        = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush2_out_valid", 64'(bus.out_valid), 64'd0);
        chk("flush2_in_ready",  64'(bus.in_ready),  64'd1);

        // Flush with one entry buffered: in_ready is high yet the offer is dropped
        send(32'h00500093, 32'h00000005, 13'h003);
        bus.in_valid = 1'b1;
        bus.in_inst  = 32'h00000000;
        flush        = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("flush1_in_ready_pre", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush1_out_valid", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        #1;
        chk("flush1_no_accept", 64'(bus.out_valid), 64'd0);
        chk("flush_ill_cnt",    64'(illegal_cnt),   64'd0);

        // Illegal instructions and the saturating counter
        bus.out_ready = 1'b1;
        send(32'h00000000, 32'h0, 13'h1000);
        send(32'h4000F033, 32'h0, 13'h1000);
        chk("ill_cnt_2", 64'(illegal_cnt), 64'd2);
        for (int i = 0; i < 9; i++) send(illegal_inst[i], 32'h0, 13'h1000);
        chk("ill_cnt_11", 64'(illegal_cnt), 64'd11);
        for (int i = 0; i < 4; i++) send(32'h00000000, 32'h0, 13'h1000);
        chk("ill_cnt_15", 64'(illegal_cnt), 64'd15);
        send(32'h00000000, 32'h0, 13'h1000);
        chk("ill_cnt_sat", 64'(illegal_cnt), 64'd15);
        send(32'h00500093, 32'h00000005, 13'h003);
        chk("ill_cnt_legal_hold", 64'(illegal_cnt), 64'd15);
        drain();

        // Asynchronous reset with the buffer full
        bus.out_ready = 1'b0;
        send(32'h00500093, 32'h00000005, 13'h003);
        send(32'h123452B7, 32'h12345000, 13'h203);
        chk("pre_rst_in_ready", 64'(bus.in_ready), 64'd0);
        #2;
        rst = 1'b1;
        sb.delete();
        #1;
        chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("arst_out_ctrl",  64'(bus.out_ctrl),  64'd0);
        chk("arst_ill_cnt",   64'(illegal_cnt),   64'd0);
        chk("arst_in_ready",  64'(bus.in_ready),  64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_out_valid", 64'(bus.out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
